state_unloader: RTL and testbench
=================================

STATE_UNLOADER -- requirements
Module: state_unloader

Interface
REQ-001 Parameter LINES, default 64: number of state lines held and streamed.
REQ-002 Parameter LINE_W, default 25: width of one state line in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  request to capture state_in; sampled only in IDLE.
REQ-006 state_in  input  LINES*LINE_W  flat final state; line i = state_in[i*LINE_W +: LINE_W].
REQ-007 busy  output  1  high in SEND and DONE.
REQ-008 out_valid  output  1  out_line/out_idx hold a line offered downstream.
REQ-009 out_ready  input  1  downstream accepts the line when out_valid && out_ready.
REQ-010 out_line  output  LINE_W  current line buf[out_idx].
REQ-011 out_idx  output  6  index of the current line, 0..LINES-1.
REQ-012 done  output  1  one-cycle pulse after the last line is accepted.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SEND, DONE.
REQ-014 In IDLE with load=1 at edge N, the block SHALL copy all LINES lines of state_in into an internal buffer, set out_idx=0, and enter SEND, so out_valid=1 from cycle N+1.
REQ-015 In SEND, out_valid=1 and out_line=buf[out_idx].
REQ-016 In SEND, out_line and out_idx SHALL hold stable while out_valid && !out_ready.
REQ-017 On out_valid && out_ready with out_idx<LINES-1, out_idx SHALL increment by 1 at the next edge.
REQ-018 On out_valid && out_ready with out_idx==LINES-1, the FSM SHALL enter DONE; out_idx SHALL not wrap past LINES-1.
REQ-019 In DONE, done=1, out_valid=0 for exactly one cycle, then IDLE with out_idx=0.
REQ-020 Whenever out_valid=0, out_line SHALL read 0.
REQ-021 load SHALL be ignored in SEND and DONE; the buffer SHALL not change outside IDLE.
REQ-022 With out_ready held at 1, a full frame SHALL take LINES cycles in SEND, and done SHALL assert at cycle N+1+LINES.
REQ-023 busy SHALL be combinationally derived from state (SEND or DONE).

Reset
REQ-024 While rst=0: state=IDLE, out_valid=0, out_line=0, out_idx=0, done=0, busy=0, regardless of clock.
REQ-025 rst asserted mid-frame SHALL abort the frame with no done pulse; buffer contents are don't-care after reset.
REQ-026 The first load after rst deasserts SHALL behave as in REQ-014.

Configuration
REQ-027 Macro STATE_UNLOADER_PARITY_EN: when defined, an output out_parity (1 bit) SHALL exist and equal the XOR of out_line bits when out_valid=1, else 0; it SHALL follow the same hold rules as out_line.
REQ-028 Without STATE_UNLOADER_PARITY_EN, port out_parity SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-029 Reset: drive rst=0 mid-SEND at out_idx=10 -> all outputs 0 immediately, no done pulse, state IDLE.
REQ-030 Full stream: line i = i+1, load at cycle 0, out_ready=1 -> out_line 1..64 on cycles 1..64, done=1 at cycle 65 only.
REQ-031 Backpressure: out_ready=0 for 5 cycles at out_idx=3 -> out_line=4 and out_idx=3 held for those 5 cycles, then advance to out_idx=4.
REQ-032 Load during busy: pulse load at out_idx=20 with a different state_in -> stream unchanged; new state_in is captured only by a load issued in IDLE.
REQ-033 Back-to-back frames: hold load=1 continuously -> frame 2 out_valid at the cycle after DONE+IDLE; second done pulse occurs 66 cycles after the first.
REQ-034 Parity (macro defined): line 0 = 25'h1FFFFFF -> out_parity=1; line 1 = 25'h0000003 -> out_parity=0.

Source files
------------

// File: rtl/state_unloader.sv
// Captures a flat LINES*LINE_W state vector on load and streams it one line per accepted beat; optional out_parity via STATE_UNLOADER_PARITY_EN.
// Latency: first line offered the cycle after load; done pulses one cycle after the last line is accepted.
// Backpressure: valid/ready; out_line/out_idx hold while out_valid && !out_ready.
module state_unloader #(
    parameter int LINES  = 64,
    parameter int LINE_W = 25
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [LINES*LINE_W-1:0]   state_in,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LINE_W-1:0]         out_line,
    output logic [5:0]                out_idx,
    output logic                      done
`ifdef STATE_UNLOADER_PARITY_EN
    ,
    output logic                      out_parity
`endif
);

    localparam logic [5:0] LAST_IDX = 6'(LINES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [5:0]        idx_q;
    logic [5:0]        idx_d;
    logic [LINE_W-1:0] line_buf [LINES];
    logic              capture;
    logic              accept;

    assign capture = rst && (state_q == IDLE) && load;
    assign accept  = (state_q == SEND) && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (accept) begin
                    // Last line parks the index instead of wrapping.
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Buffer carries no reset; its contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < LINES; i++) begin
                line_buf[i] <= state_in[i*LINE_W +: LINE_W];
            end
        end
    end

    assign out_valid = (state_q == SEND);
    assign done      = (state_q == DONE);
    assign busy      = (state_q == SEND) || (state_q == DONE);
    assign out_idx   = idx_q;
    assign out_line  = out_valid ? line_buf[idx_q] : '0;

`ifdef STATE_UNLOADER_PARITY_EN
    assign out_parity = ^out_line;
`endif

endmodule

// File: tb/tb_state_unloader.sv
// Directed bench for state_unloader: vector table plus multi-cycle sequences.
module tb_state_unloader;

    localparam int LINES  = 64;
    localparam int LINE_W = 25;

    logic                    clk;
    logic                    rst;
    logic                    load;
    logic [LINES*LINE_W-1:0] state_in;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [LINE_W-1:0]       out_line;
    logic [5:0]              out_idx;
    logic                    done;
`ifdef STATE_UNLOADER_PARITY_EN
    logic                    out_parity;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    state_unloader #(.LINES(LINES), .LINE_W(LINE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .state_in  (state_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_line  (out_line),
        .out_idx   (out_idx),
        .done      (done)
`ifdef STATE_UNLOADER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             load;
        logic             rdy;
        logic             e_vld;
        logic [5:0]       e_idx;
        logic [LINE_W-1:0] e_line;
        logic             e_done;
        logic             e_busy;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_vld, input logic [5:0] e_idx,
                              input logic [LINE_W-1:0] e_line, input logic e_done, input logic e_busy);
        chk({tag, ".vld"},  32'(out_valid), 32'(e_vld));
        chk({tag, ".idx"},  32'(out_idx),   32'(e_idx));
        chk({tag, ".line"}, 32'(out_line),  32'(e_line));
        chk({tag, ".done"}, 32'(done),      32'(e_done));
        chk({tag, ".busy"}, 32'(busy),      32'(e_busy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_state(input int base);
        for (int i = 0; i < LINES; i++) begin
            state_in[i*LINE_W +: LINE_W] = LINE_W'(i + base);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        load = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int exp_i;
        int first_done;
        int second_done;

        rst       = 1'b0;
        load      = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        set_state(1);

        // {rst_n, load, rdy} -> {vld, idx, line, done, busy} after the edge
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 25'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 25'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'd0, 25'd1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 25'd1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd1, 25'd2, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd2, 25'd3, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 25'd3, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd3, 25'd4, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'd4, 25'd5, 1'b0, 1'b1};

        for (int v = 0; v < 9; v++) begin
            rst       = vecs[v].rst_n;
            load      = vecs[v].load;
            out_ready = vecs[v].rdy;
            tick();
            check_outs($sformatf("vec%0d", v), vecs[v].e_vld, vecs[v].e_idx,
                       vecs[v].e_line, vecs[v].e_done, vecs[v].e_busy);
        end

        // Full stream with ready held high: lines 1..64 on cycles 1..64, done on 65.
        do_reset();
        set_state(1);
        load = 1'b1;
        tick();
        load = 1'b0;
        out_ready = 1'b1;
        for (int c = 1; c <= LINES; c++) begin
            check_outs($sformatf("full.c%0d", c), 1'b1, 6'(c - 1), LINE_W'(c), 1'b0, 1'b1);
            tick();
        end
        check_outs("full.done", 1'b0, 6'd63, 25'd0, 1'b1, 1'b1);
        tick();
        check_outs("full.idle", 1'b0, 6'd0, 25'd0, 1'b0, 1'b0);

        // Backpressure at idx 3 for five cycles.
        load = 1'b1;
        out_ready = 1'b0;
        tick();
        load = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_outs($sformatf("bp.hold%0d", k), 1'b1, 6'd3, 25'd4, 1'b0, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check_outs("bp.adv", 1'b1, 6'd4, 25'd5, 1'b0, 1'b1);

        // Asynchronous reset mid-frame at idx 10.
        for (int k = 0; k < 6; k++) tick();
        chk("rst.pre_idx", 32'(out_idx), 32'd10);
        #2;
        rst = 1'b0;
        #1;
        check_outs("rst.async", 1'b0, 6'd0, 25'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_outs($sformatf("rst.held%0d", k), 1'b0, 6'd0, 25'd0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        tick();
        check_outs("rst.idle", 1'b0, 6'd0, 25'd0, 1'b0, 1'b0);

        // Load pulsed mid-frame with different data must be ignored.
        set_state(1);
        load = 1'b1;
        tick();
        load = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("lb.idx20", 32'(out_idx), 32'd20);
        set_state(100);
        load = 1'b1;
        tick();
        load = 1'b0;
        exp_i = 21;
        while (exp_i < LINES) begin
            chk($sformatf("lb.idx%0d", exp_i), 32'(out_idx), 32'(exp_i));
            chk($sformatf("lb.line%0d", exp_i), 32'(out_line), 32'(exp_i + 1));
            tick();
            exp_i++;
        end
        chk("lb.done", 32'(done), 32'd1);
        tick();
        chk("lb.idle_vld", 32'(out_valid), 32'd0);
        load = 1'b1;
        tick();
        load = 1'b0;
        check_outs("lb.newload", 1'b1, 6'd0, 25'd100, 1'b0, 1'b1);

        // Back-to-back frames with load held high.
        do_reset();
        set_state(1);
        load = 1'b1;
        out_ready = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (done) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (c == 66) chk("b2b.c66_vld", 32'(out_valid), 32'd0);
            if (c == 67) begin
                chk("b2b.c67_vld", 32'(out_valid), 32'd1);
                chk("b2b.c67_line", 32'(out_line), 32'd1);
            end
        end
        load = 1'b0;
        chk("b2b.first_done", 32'(first_done), 32'd65);
        chk("b2b.gap", 32'(second_done - first_done), 32'd66);

`ifdef STATE_UNLOADER_PARITY_EN
        do_reset();
        chk("par.idle", 32'(out_parity), 32'd0);
        set_state(1);
        state_in[0 +: LINE_W]      = 25'h1FFFFFF;
        state_in[LINE_W +: LINE_W] = 25'h0000003;
        load = 1'b1;
        out_ready = 1'b0;
        tick();
        load = 1'b0;
        chk("par.line0", 32'(out_parity), 32'd1);
        tick();
        chk("par.line0_hold", 32'(out_parity), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("par.line1", 32'(out_parity), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
